// File: rtl/pool_window_scheduler.sv
// pool_window_scheduler
//
// This block feeds one image frame of pixels into the max-pool datapath and
// tracks where each pixel sits in the frame. It tracks the raster row and
// column of every accepted pixel. When an accepted pixel is the bottom-right
// corner of a stride-aligned pooling window, the block raises a window tag.
// The tag carries that window's output coordinates. The pooling datapath
// trusts this tag instead of its own delay counter.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin a frame (sampled only in IDLE)
//   busy       high while streaming or draining a frame
//   done       one-cycle pulse after the last window handshake of a frame
//   pix_valid  source has a pixel
//   pix_data   pixel value
//   pix_ready  block accepts the pixel this cycle
//   dp_enable  datapath shift enable (pix_valid & pix_ready)
//   dp_data    pixel value passed through to the datapath
//   win_valid  a window completed; win_row/win_col are valid
//   win_ready  consumer accepts the window tag
//   win_row    output row index of the completed window
//   win_col    output column index of the completed window
//   win_count  windows handshaken in the current frame

module pool_window_scheduler #(
  parameter int BITWIDTH     = 8,
  parameter int FILTER_WIDTH = 3,
  parameter int IMAGE_WIDTH  = 11,
  parameter int IMAGE_HEIGHT = 11,
  parameter int STRIDE       = 2,
  localparam int MAX_DIM     = (IMAGE_WIDTH > IMAGE_HEIGHT) ? IMAGE_WIDTH : IMAGE_HEIGHT,
  localparam int CW          = $clog2(MAX_DIM + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                pix_valid,
  input  logic [BITWIDTH-1:0] pix_data,
  output logic                pix_ready,
  output logic                dp_enable,
  output logic [BITWIDTH-1:0] dp_data,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [CW-1:0]       win_row,
  output logic [CW-1:0]       win_col,
  output logic [2*CW-1:0]     win_count
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // The constants are sized to the counters, so every comparison uses equal widths.
  localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] WIN_START = CW'(FILTER_WIDTH - 1);
  localparam logic [CW-1:0] PH_LAST   = CW'(STRIDE - 1);

  state_t        state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [CW-1:0] rph;
  logic [CW-1:0] cph;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;

  logic accept;
  logic handshake;
  logic col_wrap;
  logic frame_last;
  logic row_in_win;
  logic col_in_win;
  logic hit;
  logic start_frame;

  // Input stalls while an unaccepted window tag is pending. This guarantees
  // that a new hit can never overwrite a tag the consumer has not seen yet.
  assign pix_ready   = (state == STREAM) && !(win_valid && !win_ready);
  assign accept      = pix_valid && pix_ready;
  assign dp_enable   = accept;
  assign dp_data     = pix_data;
  assign handshake   = win_valid && win_ready;

  assign col_wrap    = (col == COL_LAST);
  assign frame_last  = col_wrap && (row == ROW_LAST);
  assign row_in_win  = (row >= WIN_START);
  assign col_in_win  = (col >= WIN_START);
  assign hit         = accept && row_in_win && col_in_win && (rph == '0) && (cph == '0);
  assign start_frame = (state == IDLE) && start;

  // Frame sequencing. busy and done are registered alongside the state, so
  // downstream logic sees them without a decode of the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= STREAM;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (accept && frame_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last hit's tag may still be waiting for the consumer.
          if (!win_valid || win_ready) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Raster position and stride phases. A phase stays at 0 until its axis
  // reaches the first complete window position (F-1). After that it cycles
  // 0..S-1, so a phase of 0 marks a stride-aligned window edge without any
  // division. out_row/out_col count completed window positions. They supply
  // the tag coordinates directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      rph       <= '0;
      cph       <= '0;
      out_row   <= '0;
      out_col   <= '0;
      win_count <= '0;
    end else if (start_frame) begin
      row       <= '0;
      col       <= '0;
      rph       <= '0;
      cph       <= '0;
      out_row   <= '0;
      out_col   <= '0;
      win_count <= '0;
    end else begin
      if (handshake) begin
        win_count <= win_count + 1'b1;
      end
      if (accept) begin
        if (col_wrap) begin
          col     <= '0;
          cph     <= '0;
          out_col <= '0;
          if (row == ROW_LAST) begin
            row     <= '0;
            rph     <= '0;
            out_row <= '0;
          end else begin
            row <= row + 1'b1;
            if (row_in_win) begin
              rph <= (rph == PH_LAST) ? '0 : rph + 1'b1;
            end
            // A window row just finished, so the next window row begins.
            if (row_in_win && (rph == '0)) begin
              out_row <= out_row + 1'b1;
            end
          end
        end else begin
          col <= col + 1'b1;
          if (col_in_win) begin
            cph <= (cph == PH_LAST) ? '0 : cph + 1'b1;
          end
          if (hit) begin
            out_col <= out_col + 1'b1;
          end
        end
      end
    end
  end

  // Window tag register. A hit always wins over the drop, because a hit can
  // only occur in a cycle where any pending tag is also being handshaken.
  always_ff @(posedge clock) begin
    if (reset) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (hit) begin
      win_valid <= 1'b1;
      win_row   <= out_row;
      win_col   <= out_col;
    end else if (handshake) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_window_scheduler.sv
// Testbench for pool_window_scheduler: a default-size instance driven with
// randomized traffic against a frame-level reference model, plus a small
// F=2, S=2, 5x5 instance driven with one directed frame.

module tb_pool_window_scheduler;

  localparam int F     = 3;
  localparam int S     = 2;
  localparam int W     = 11;
  localparam int H     = 11;
  localparam int OUT_W = (W - F) / S + 1;
  localparam int OUT_H = (H - F) / S + 1;
  localparam int CW    = $clog2(((W > H) ? W : H) + 1);

  localparam int SF    = 2;
  localparam int SS    = 2;
  localparam int SW    = 5;
  localparam int SH    = 5;
  localparam int SCW   = $clog2(((SW > SH) ? SW : SH) + 1);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // default instance signals
  logic              reset, start, busy, done;
  logic              pix_valid, pix_ready, dp_enable;
  logic [7:0]        pix_data, dp_data;
  logic              win_valid, win_ready;
  logic [CW-1:0]     win_row, win_col;
  logic [2*CW-1:0]   win_count;

  // small instance signals
  logic              s_reset, s_start, s_busy, s_done;
  logic              s_pix_valid, s_pix_ready, s_dp_enable;
  logic [7:0]        s_pix_data, s_dp_data;
  logic              s_win_valid, s_win_ready;
  logic [SCW-1:0]    s_win_row, s_win_col;
  logic [2*SCW-1:0]  s_win_count;

  pool_window_scheduler #(
    .BITWIDTH(8), .FILTER_WIDTH(F), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .STRIDE(S)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .dp_enable(dp_enable), .dp_data(dp_data),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col), .win_count(win_count)
  );

  pool_window_scheduler #(
    .BITWIDTH(8), .FILTER_WIDTH(SF), .IMAGE_WIDTH(SW), .IMAGE_HEIGHT(SH), .STRIDE(SS)
  ) dut_small (
    .clock(clock), .reset(s_reset), .start(s_start), .busy(s_busy), .done(s_done),
    .pix_valid(s_pix_valid), .pix_data(s_pix_data), .pix_ready(s_pix_ready),
    .dp_enable(s_dp_enable), .dp_data(s_dp_data),
    .win_valid(s_win_valid), .win_ready(s_win_ready),
    .win_row(s_win_row), .win_col(s_win_col), .win_count(s_win_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Frame-level reference model: pixels are numbered in raster order, and a
  // window completes on pixel (r,c) when both axes sit on the stride grid.
  typedef enum int {M_IDLE, M_STREAM, M_DRAIN, M_DONE} mphase_t;
  mphase_t m_phase = M_IDLE;
  bit      m_pend  = 0;
  int      m_prow  = 0;
  int      m_pcol  = 0;
  int      m_cnt   = 0;
  int      m_acc   = 0;
  bit      mon_en  = 0;

  // Observed per-frame statistics of the default instance.
  int obs_acc, obs_done, obs_first_pix, obs_cnt_at_done;
  bit obs_first_seen;
  int obs_rows[$];
  int obs_cols[$];

  always @(negedge clock) begin : monitor
    logic exp_ready, acc, hs, pend_old;
    int r, c;
    if (mon_en) begin
      exp_ready = (m_phase == M_STREAM) && !(m_pend && !win_ready);
      checkOutput("pix_ready", pix_ready, exp_ready);
      checkOutput("dp_enable", dp_enable, pix_valid && exp_ready);
      if (dp_enable) checkOutput("dp_data", dp_data, pix_data);
      checkOutput("win_valid", win_valid, m_pend);
      checkOutput("win_row", win_row, m_prow);
      checkOutput("win_col", win_col, m_pcol);
      checkOutput("win_count", win_count, m_cnt);
      checkOutput("busy", busy, (m_phase == M_STREAM) || (m_phase == M_DRAIN));
      checkOutput("done", done, m_phase == M_DONE);

      if (win_valid && !obs_first_seen) begin
        obs_first_seen = 1;
        obs_first_pix  = obs_acc;
      end
      if (dp_enable) obs_acc++;
      if (win_valid && win_ready) begin
        obs_rows.push_back(int'(win_row));
        obs_cols.push_back(int'(win_col));
      end
      if (done) begin
        obs_done++;
        obs_cnt_at_done = int'(win_count);
      end

      if (reset) begin
        m_phase = M_IDLE;
        m_pend  = 0;
        m_prow  = 0;
        m_pcol  = 0;
        m_cnt   = 0;
        m_acc   = 0;
      end else begin
        acc      = pix_valid && exp_ready;
        hs       = m_pend && win_ready;
        pend_old = m_pend;
        if (hs) begin
          m_cnt++;
          m_pend = 0;
        end
        if (acc) begin
          r = m_acc / W;
          c = m_acc % W;
          if (r >= F-1 && c >= F-1 && (r-(F-1)) % S == 0 && (c-(F-1)) % S == 0) begin
            m_pend = 1;
            m_prow = (r-(F-1)) / S;
            m_pcol = (c-(F-1)) / S;
          end
          m_acc++;
        end
        case (m_phase)
          M_IDLE:   if (start) begin m_phase = M_STREAM; m_cnt = 0; m_acc = 0; end
          M_STREAM: if (acc && m_acc == W*H) m_phase = M_DRAIN;
          M_DRAIN:  if (!pend_old || win_ready) m_phase = M_DONE;
          default:  m_phase = M_IDLE;
        endcase
      end
    end
  end

  // Small-instance observation.
  int s_acc, s_done_cnt, s_cnt_at_done;
  int s_rows[$];
  int s_cols[$];

  always @(negedge clock) begin
    if (!s_reset) begin
      if (s_dp_enable) s_acc++;
      if (s_win_valid && s_win_ready) begin
        s_rows.push_back(int'(s_win_row));
        s_cols.push_back(int'(s_win_col));
      end
      if (s_done) begin
        s_done_cnt++;
        s_cnt_at_done = int'(s_win_count);
      end
    end
  end

  // One frame on the default instance. Inputs pulse start at random and
  // drive pix_valid during IDLE to show that neither has an effect.
  task automatic applyStimulus(input int valid_pct, input int ready_pct,
                               input int stall_cycles, input int abort_after);
    int  cycles, stall_left;
    bit  stalled, aborted;
    obs_acc = 0; obs_done = 0; obs_first_pix = -1; obs_cnt_at_done = -1;
    obs_first_seen = 0;
    obs_rows.delete();
    obs_cols.delete();
    repeat (3) begin
      @(posedge clock); #1;
      start = 0; pix_valid = 1; pix_data = 8'($urandom); win_ready = 1;
    end
    @(posedge clock); #1;
    start = 1; pix_valid = ($urandom_range(99) < valid_pct); pix_data = 8'($urandom);
    cycles = 0; stall_left = 0; stalled = 0; aborted = 0;
    while (obs_done == 0 && !aborted && cycles < 4000) begin
      @(posedge clock); #1;
      cycles++;
      start     = ($urandom_range(15) == 0);
      pix_valid = ($urandom_range(99) < valid_pct);
      pix_data  = 8'($urandom);
      if (stall_left > 0) begin
        win_ready = 0;
        stall_left--;
      end else if (stall_cycles > 0 && !stalled && win_valid) begin
        stalled    = 1;
        win_ready  = 0;
        stall_left = stall_cycles - 1;
      end else begin
        win_ready = ($urandom_range(99) < ready_pct);
      end
      if (abort_after > 0 && obs_acc >= abort_after) begin
        reset = 1;
        @(posedge clock); #1;
        reset   = 0;
        aborted = 1;
      end
    end
    start = 0; pix_valid = 0; win_ready = 1;
    checkOutput("frame_finished", (obs_done != 0) || aborted, 1);
    if (aborted) begin
      repeat (3) @(posedge clock);
      #1;
      checkOutput("abort_no_done", obs_done, 0);
    end else begin
      checkOutput("accepted_pixels", obs_acc, W*H);
      checkOutput("done_pulses", obs_done, 1);
      checkOutput("win_count_at_done", obs_cnt_at_done, OUT_W*OUT_H);
      checkOutput("first_hit_pixel", obs_first_pix, (F-1)*W + F);
      checkOutput("window_total", obs_rows.size(), OUT_W*OUT_H);
      for (int i = 0; i < obs_rows.size() && i < OUT_W*OUT_H; i++) begin
        checkOutput("window_coord", obs_rows[i]*256 + obs_cols[i], (i/OUT_W)*256 + (i%OUT_W));
      end
    end
  endtask

  task automatic runSmallFrame();
    int cycles;
    int er[$];
    int ec[$];
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        if (r >= SF-1 && c >= SF-1 && (r-(SF-1)) % SS == 0 && (c-(SF-1)) % SS == 0) begin
          er.push_back((r-(SF-1)) / SS);
          ec.push_back((c-(SF-1)) / SS);
        end
    s_acc = 0; s_done_cnt = 0; s_cnt_at_done = -1;
    s_rows.delete();
    s_cols.delete();
    @(posedge clock); #1;
    s_reset = 0;
    checkOutput("s_reset_busy", s_busy, 0);
    checkOutput("s_reset_win_valid", s_win_valid, 0);
    s_start = 1; s_pix_valid = 1; s_win_ready = 1;
    @(posedge clock); #1;
    s_start = 0;
    cycles = 0;
    while (s_done_cnt == 0 && cycles < 500) begin
      @(posedge clock); #1;
      s_pix_data = 8'($urandom);
      cycles++;
    end
    s_pix_valid = 0;
    checkOutput("s_frame_finished", s_done_cnt, 1);
    checkOutput("s_accepted_pixels", s_acc, SW*SH);
    checkOutput("s_win_count_at_done", s_cnt_at_done, 4);
    checkOutput("s_window_total", s_rows.size(), er.size());
    for (int i = 0; i < s_rows.size() && i < er.size(); i++) begin
      checkOutput("s_window_coord", s_rows[i]*256 + s_cols[i], er[i]*256 + ec[i]);
    end
  endtask

  initial begin
    reset = 1; start = 0; pix_valid = 0; pix_data = 0; win_ready = 1;
    s_reset = 1; s_start = 0; s_pix_valid = 0; s_pix_data = 0; s_win_ready = 1;
    @(posedge clock); #1;
    mon_en = 1;
    @(posedge clock); #1;
    reset = 0;
    $display("[TB] default instance frames");
    applyStimulus(100, 100, 0, 0);
    applyStimulus(100, 100, 5, 0);
    applyStimulus(50, 100, 0, 0);
    applyStimulus(100, 100, 0, 40);
    applyStimulus(100, 100, 0, 0);
    applyStimulus(60, 50, 0, 0);
    $display("[TB] small instance frame");
    runSmallFrame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_window_scheduler.md
Name: pool_window_scheduler

Overview:
- Sequences one image frame of pixels into the max-pool datapath.
- Tracks the raster row/column of every pixel it accepts and gates the datapath shift enable.
- Flags each pixel that completes a stride-aligned pooling window, with that window's output coordinates, over a valid/ready handshake.
- Sits between the pixel source and the pooling datapath. It replaces the datapath's free-running delay counter as the authority on window position.

Parameters:
- BITWIDTH, 8, pixel width.
- FILTER_WIDTH, 3, square pooling window side F.
- IMAGE_WIDTH, 11, pixels per row W (W >= F).
- IMAGE_HEIGHT, 11, rows per frame H (H >= F).
- STRIDE, 2, window step S in both axes (1 <= S <= F).
- Derived: OUT_W = (W-F)/S+1, OUT_H = (H-F)/S+1, integer division. CW = $clog2(max(W,H)+1).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high in STREAM and DRAIN
- done  out  1  one-cycle pulse after the last window handshake of a frame
- pix_valid  in  1  source has a pixel
- pix_data  in  BITWIDTH  pixel value
- pix_ready  out  1  block accepts the pixel this cycle
- dp_enable  out  1  datapath shift enable; equals pix_valid & pix_ready (combinational)
- dp_data  out  BITWIDTH  equals pix_data (combinational pass-through)
- win_valid  out  1  a window completed; coordinates valid
- win_ready  in  1  consumer accepts the window tag
- win_row  out  CW  output row index, 0..OUT_H-1
- win_col  out  CW  output column index, 0..OUT_W-1
- win_count  out  CW*2  windows handshaken in the current frame

Behaviour:
- Reset values: busy=0, done=0, pix_ready=0, win_valid=0, win_row=0, win_col=0, win_count=0. Internal row, col, phase and state registers are cleared and state=IDLE.
- A reset asserted mid-frame abandons the frame immediately. No done pulse is issued.
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE: on start=1, clear row/col/phases/win_count and go to STREAM.
  - STREAM: accept pixels. On accepting pixel (H-1, W-1), go to DRAIN.
  - DRAIN: wait until win_valid=0, or until the handshake completes this cycle, then go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- pix_ready = (state==STREAM) && !(win_valid && !win_ready). Input stalls while a window tag is pending and unaccepted. When win_valid & win_ready, a new pixel is accepted the same cycle.
- Accept (pix_valid & pix_ready):
  - col increments, wrapping W-1 -> 0. On that wrap, row increments.
  - Column phase cph counts 0..S-1 and starts counting once col >= F-1. It resets to 0 on row wrap.
  - Row phase rph behaves the same way with respect to row.
  - No division or modulo operators are used.
- Window hit: the accepted pixel satisfies row >= F-1, col >= F-1, rph==0 and cph==0.
  - On the next cycle win_valid=1, win_row=(row-(F-1))/S and win_col=(col-(F-1))/S. Both indices are maintained as incrementing counters.
  - Latency from accept to win_valid is 1 cycle.
- win_valid holds, with stable coordinates, until win_ready. It drops the cycle after the handshake unless a new hit was registered in the handshake cycle.
- win_count increments on each handshake.
- A hit cannot occur while win_valid & !win_ready, because input is stalled.
- Pixels beyond the (W-F)%S trailing columns/rows are accepted and shifted into the datapath, but produce no hit.
- start while busy is ignored.
- pix_valid outside STREAM is ignored and dp_enable stays 0.
- Frame invariant: win_count = OUT_W*OUT_H when done pulses.

Test Plan:
- Defaults (F=3, S=2, W=H=11), continuous pix_valid, win_ready=1 -> 121 pixels accepted. First win_valid one cycle after the 25th accepted pixel (row 2, col 2) with (0,0). Second hit at pixel 27 with (0,1). Last hit at pixel 121 with (4,4). done pulses once, win_count=25.
- Defaults, win_ready held 0 for 5 cycles at the first hit -> pix_ready=0 for those cycles, dp_enable=0, win_row/col held at (0,0). The pixel at col 3 is accepted in the handshake cycle.
- F=2, S=2, W=H=5 -> hits only at rows/cols 1 and 3. The 4 windows are (0,0),(0,1),(1,0),(1,1). Row 4 and col 4 give no hit. win_count=4.
- Random pix_valid gaps (~50%), defaults -> the same 25 coordinates in raster order. dp_enable count = 121.
- reset pulsed after 40 pixels, then start -> outputs at reset values the cycle after reset. No done pulse. The new frame restarts at (0,0) and yields 25 windows.
- start pulsed during STREAM, and pix_valid while IDLE -> no effect. pix_ready=0 and dp_enable=0 while IDLE.
